lcd_dma_reader: RTL
===================

# lcd_dma_reader

AXI3 burst-read master feeding the LCD controller's DMA interface. It accepts a single-burst read request, given as a 64-bit-word address, on the DMA_START/DMA_READY handshake. It issues one INCR burst of 64-bit beats on a Zynq HP port and returns each beat as two 32-bit words on DMA_RD_DATA/DMA_RD_DATA_VALID, low half first, at up to one word per CLK. It runs entirely in the CLK (DMA) domain; the controller's FIFO is the consumer and never back-pressures.

## Interface
- BURST_LEN, 4: 64-bit beats per burst (1..16); the request yields 2*BURST_LEN words.
- ARCACHE_VAL, 4'b0011: constant driven on M_AXI_ARCACHE.
- CLK  in  1  clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high.
- DMA_RD_ADDR  in  29  burst start address in 8-byte units; sampled when the request is accepted.
- DMA_START  in  1  one-cycle request strobe; honoured only while DMA_READY=1.
- DMA_READY  out  1  1 = idle, can accept a request.
- DMA_RD_DATA  out  32  returned word; 0 whenever DMA_RD_DATA_VALID=0.
- DMA_RD_DATA_VALID  out  1  1 for each cycle carrying a word.
- DMA_ERROR  out  1  sticky: an RRESP or RLAST violation was seen; cleared only by RESET.
- M_AXI_ARADDR  out  32  byte address = {DMA_RD_ADDR, 3'b000}.
- M_AXI_ARLEN  out  4  BURST_LEN-1.
- M_AXI_ARSIZE  out  3  3'b011 (8 bytes).
- M_AXI_ARBURST  out  2  2'b01 (INCR).
- M_AXI_ARCACHE  out  4  ARCACHE_VAL.
- M_AXI_ARVALID / M_AXI_ARREADY  out/in  1  address handshake.
- M_AXI_RDATA  in  64; M_AXI_RRESP  in  2; M_AXI_RLAST  in  1.
- M_AXI_RVALID / M_AXI_RREADY  in/out  1  read data handshake.

## Operation
- FSM states: IDLE, ADDR, RD, LO, HI.
- IDLE: DMA_READY=1. DMA_START=1 latches the address, clears the beat counter and goes to ADDR.
- ADDR: ARVALID=1, with ARADDR and ARLEN held stable. ARVALID&ARREADY goes to RD.
- RD: RREADY=1. On RVALID&RREADY the FSM captures RDATA into a 64-bit holding register, increments the beat counter, and goes to LO.
- LO: drives DMA_RD_DATA=hold[31:0] with VALID=1 and RREADY=0, then goes to HI.
- HI: drives DMA_RD_DATA=hold[63:32] with VALID=1.
  - If beats < BURST_LEN: RREADY=1. A handshake in this cycle captures the next beat and goes to LO; otherwise the FSM goes to RD.
  - If beats == BURST_LEN: RREADY=0 and the FSM goes to IDLE.
- Burst end is set by the beat counter, never by RLAST.
- DMA_ERROR is set by any of these on an accepted beat:
  - RRESP != 2'b00;
  - RLAST=1 on a beat other than the last;
  - RLAST=0 on the last beat.
- Data of an erroneous beat is still delivered.
- DMA_START outside IDLE is ignored and has no side effects.
- Beat counter: $clog2(BURST_LEN+1) bits; it never wraps within a burst.

## Timing
- Reset values: DMA_READY=1, DMA_RD_DATA=0, DMA_RD_DATA_VALID=0, DMA_ERROR=0, ARVALID=0, RREADY=0, FSM=IDLE. The AR address/len outputs are 0 until the first request.
- All DMA_* outputs and ARVALID/RREADY are registered or decoded directly from FSM state; no combinational input-to-output paths.
- DMA_START at cycle t gives DMA_READY=0 and ARVALID=1 at t+1.
- ARREADY at cycle a gives RREADY=1 at a+1.
- A beat accepted at cycle r gives its low word at r+1 and high word at r+2.
- With RVALID continuously high, the burst emits 2*BURST_LEN consecutive VALID cycles with no gaps.
- DMA_READY=1 on the cycle after the final HI. The earliest next accept is that cycle, so the next ARVALID appears 2 cycles after the last word.
- RESET mid-burst: immediate return to reset values and the in-flight burst is abandoned. The AXI interconnect must be reset together with this block.

## Structure
- Package lcd_dma_pkg holds:
  - the FSM state enum;
  - AXI constants AXSIZE_8B=3'b011, AXBURST_INCR=2'b01, RESP_OKAY=2'b00;
  - the default burst length.
- Single flat module; no sub-module.

## Test plan
- Basic burst: BURST_LEN=4, ARREADY=1, RVALID always high, addr 29'h1000_0000, beats 64'h{2k+1,2k}. Required: ARADDR=32'h8000_0000, ARLEN=3, 8 back-to-back valid words 0..7, DMA_READY back 1 cycle after the last word.
- AR stall: ARREADY withheld 5 cycles. Required: ARVALID and ARADDR stable throughout, RREADY=0 until 1 cycle after the handshake.
- R gaps: RVALID low for 3 cycles between beats 1 and 2. Required: VALID gaps, word order intact, exactly 8 words.
- Busy request: DMA_START pulsed during the LO state. Required: no second ARVALID and address unchanged; a DMA_START at the IDLE return is accepted.
- Error: RRESP=2'b10 on beat 2, and in a second burst RLAST on beat 1. Required: DMA_ERROR=1 and sticky, all 8 words still delivered in each burst.
- Reset mid-burst: RESET after 3 words. Required: all outputs at reset values the next cycle, and a new request then completes cleanly.

Source files
------------

// File: rtl/lcd_dma_reader_pkg.sv
// Shared types and AXI constants for the LCD DMA burst reader.
package lcd_dma_pkg;

  localparam int unsigned DEFAULT_BURST_LEN = 4;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned DMA_ADDR_W = 29;
  localparam int unsigned DMA_DATA_W = 32;

  localparam logic [2:0] AXSIZE_8B    = 3'b011;
  localparam logic [1:0] AXBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD,
    ST_LO,
    ST_HI
  } state_e;

endpackage

// File: rtl/lcd_dma_reader_if.sv
// AXI3 read-address and read-data channels of a Zynq HP port.
interface lcd_dma_reader_if;
  import lcd_dma_pkg::*;

  logic [AXI_ADDR_W-1:0] M_AXI_ARADDR;
  logic [3:0]            M_AXI_ARLEN;
  logic [2:0]            M_AXI_ARSIZE;
  logic [1:0]            M_AXI_ARBURST;
  logic [3:0]            M_AXI_ARCACHE;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [AXI_DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RLAST;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARCACHE, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
           M_AXI_ARCACHE, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
  );

endinterface

// File: rtl/lcd_dma_reader.sv
// Single-burst AXI3 read master: fetches BURST_LEN 64-bit beats and streams
// them to the LCD controller FIFO as 32-bit words, low half first.
module lcd_dma_reader
  import lcd_dma_pkg::*;
#(
  parameter int unsigned BURST_LEN   = DEFAULT_BURST_LEN,
  parameter logic [3:0]  ARCACHE_VAL = 4'b0011
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DMA_ADDR_W-1:0] DMA_RD_ADDR,
  input  logic                  DMA_START,
  output logic                  DMA_READY,
  output logic [DMA_DATA_W-1:0] DMA_RD_DATA,
  output logic                  DMA_RD_DATA_VALID,
  output logic                  DMA_ERROR,
  lcd_dma_reader_if.master      axi
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [AXI_DATA_W-1:0] hold_q, hold_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic [3:0]            arlen_q, arlen_d;
  logic                  err_q, err_d;
  logic                  rready_c;
  logic                  beat_acc_c;
  logic                  last_beat_c;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      hold_q     <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      hold_q     <= hold_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      err_q      <= err_d;
    end
  end

  // Next-state, beat capture and error tracking
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    hold_d      = hold_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    err_d       = err_q;
    rready_c    = 1'b0;
    beat_acc_c  = 1'b0;
    last_beat_c = (beat_cnt_q == CNT_W'(BURST_LEN - 1));

    unique case (state_q)
      ST_IDLE: begin
        if (DMA_START) begin
          araddr_d   = {DMA_RD_ADDR, 3'b000};
          arlen_d    = 4'(BURST_LEN - 1);
          beat_cnt_d = '0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (axi.M_AXI_ARREADY) state_d = ST_RD;
      end
      ST_RD: begin
        rready_c = 1'b1;
        if (axi.M_AXI_RVALID) begin
          beat_acc_c = 1'b1;
          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        state_d = ST_HI;
      end
      ST_HI: begin
        // Overlap the next beat's handshake with the high-word cycle
        if (beat_cnt_q < CNT_W'(BURST_LEN)) begin
          rready_c = 1'b1;
          if (axi.M_AXI_RVALID) begin
            beat_acc_c = 1'b1;
            state_d    = ST_LO;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Erroneous beats are still delivered; the error only latches
    if (beat_acc_c) begin
      hold_d     = axi.M_AXI_RDATA;
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      if ((axi.M_AXI_RRESP != RESP_OKAY) || (axi.M_AXI_RLAST != last_beat_c))
        err_d = 1'b1;
    end
  end

  assign DMA_READY         = (state_q == ST_IDLE);
  assign DMA_RD_DATA_VALID = (state_q == ST_LO) || (state_q == ST_HI);
  assign DMA_ERROR         = err_q;

  always_comb begin
    DMA_RD_DATA = '0;
    if (state_q == ST_LO)      DMA_RD_DATA = hold_q[31:0];
    else if (state_q == ST_HI) DMA_RD_DATA = hold_q[63:32];
  end

  assign axi.M_AXI_ARADDR  = araddr_q;
  assign axi.M_AXI_ARLEN   = arlen_q;
  assign axi.M_AXI_ARSIZE  = AXSIZE_8B;
  assign axi.M_AXI_ARBURST = AXBURST_INCR;
  assign axi.M_AXI_ARCACHE = ARCACHE_VAL;
  assign axi.M_AXI_ARVALID = (state_q == ST_ADDR);
  assign axi.M_AXI_RREADY  = rready_c;

endmodule
